instr_issue_seq: RTL and testbench

Host-side instruction sequencer that drives the simple CPU's instruction interface (in/load/s/w). It buffers 16-bit instructions written by a host or testbench in a small FIFO. When enabled, it issues them to the CPU one at a time using the load -> start -> wait-for-completion handshake. A timeout catches instructions that never complete, for example an undecodable opcode that leaves the CPU stuck in Decode.

---
 rtl/instr_issue_pkg.sv | 42 ++++
 rtl/instr_fifo.sv | 65 ++++++
 rtl/instr_issue_seq.sv | 138 +++++++++++++
 tb/tb_instr_issue_seq.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_issue_pkg.sv
// Shared types and constants for the instruction issue sequencer.
// Encoding helpers build words for the attached simple CPU.
package instr_issue_pkg;

  localparam int INSTR_W = 16;

  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  localparam int ST_IDLE  = 0;
  localparam int ST_LOAD  = 1;
  localparam int ST_START = 2;
  localparam int ST_WBUSY = 3;
  localparam int ST_WDONE = 4;
  localparam int ST_ERR   = 5;

  typedef enum logic [5:0] {
    IDLE  = 6'b000001,
    LOAD  = 6'b000010,
    START = 6'b000100,
    WBUSY = 6'b001000,
    WDONE = 6'b010000,
    ERR   = 6'b100000
  } state_e;

  function automatic logic [INSTR_W-1:0] mk_mov(
    input logic [1:0] rd,
    input logic [7:0] imm
  );
    return {OPC_MOV, 3'b100, rd, imm};
  endfunction

  function automatic logic [INSTR_W-1:0] mk_alu(
    input logic [1:0] op,
    input logic [1:0] rd,
    input logic [1:0] ra,
    input logic [1:0] rb
  );
    return {OPC_ALU, op, 1'b0, rd, ra, rb, 4'h0};
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// Instruction buffer: power-of-two ring with occupancy count.
// Head word is presented combinationally on data_o.
module instr_fifo
  import instr_issue_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int W     = INSTR_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push_i,
  input  logic [W-1:0]           data_i,
  input  logic                   pop_i,
  output logic [W-1:0]           data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (count_q == CNT_FULL);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // Fullness is judged before any same-cycle pop.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      if (do_push && !do_pop) begin
        count_q <= count_q + (AW+1)'(1);
      end else if (!do_push && do_pop) begin
        count_q <= count_q - (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/instr_issue_seq.sv
// Issues buffered instructions to the CPU with a load/start/wait
// handshake; a per-wait-state timeout traps hung instructions.
module instr_issue_seq
  import instr_issue_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_valid,
  input  logic [INSTR_W-1:0]     wr_data,
  output logic                   wr_ready,
  input  logic                   run,
  output logic [INSTR_W-1:0]     cpu_in,
  output logic                   cpu_load,
  output logic                   cpu_s,
  input  logic                   cpu_w,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [15:0]            issued_cnt,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  state_e        state_q;
  logic          load_q;
  logic          start_q;
  logic          busy_q;
  logic          done_q;
  logic          err_q;
  logic [15:0]   issued_q;
  logic [TW-1:0] tmo_q;

  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  assign wr_ready   = !full;
  assign push       = wr_valid && wr_ready;
  assign pop        = state_q[ST_LOAD];

  assign cpu_load   = load_q;
  assign cpu_s      = start_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign issued_cnt = issued_q;

  instr_fifo #(
    .DEPTH (DEPTH),
    .W     (INSTR_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .data_i  (wr_data),
    .pop_i   (pop),
    .data_o  (cpu_in),
    .full_o  (full),
    .empty_o (empty),
    .count_o (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      load_q   <= 1'b0;
      start_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      issued_q <= '0;
      tmo_q    <= '0;
    end else begin
      load_q  <= 1'b0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
      unique case (1'b1)
        state_q[ST_IDLE]: begin
          // Loading while the CPU executes would clobber its IR.
          if (run && !empty && cpu_w) begin
            state_q <= LOAD;
            load_q  <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        state_q[ST_LOAD]: begin
          state_q <= START;
          start_q <= 1'b1;
        end
        state_q[ST_START]: begin
          state_q <= WBUSY;
          tmo_q   <= '0;
        end
        state_q[ST_WBUSY]: begin
          // w stays high through Decode, so only a low w means launched.
          if (!cpu_w) begin
            state_q <= WDONE;
            tmo_q   <= '0;
          end else if (tmo_q == TMO_LAST) begin
            state_q <= ERR;
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        state_q[ST_WDONE]: begin
          if (cpu_w) begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            issued_q <= issued_q + 16'd1;
            done_q   <= empty && !push;
          end else if (tmo_q == TMO_LAST) begin
            state_q <= ERR;
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        state_q[ST_ERR]: begin
          state_q <= ERR;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_issue_seq.sv
// Random and directed bench for instr_issue_seq with a behavioural
// CPU model and an issue-order scoreboard.
module tb_instr_issue_seq;
  import instr_issue_pkg::*;

  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr_valid = 1'b0;
  logic [15:0] wr_data = '0;
  logic        wr_ready;
  logic        run = 1'b0;
  logic [15:0] cpu_in;
  logic        cpu_load;
  logic        cpu_s;
  logic        cpu_w;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] issued_cnt;
  logic [3:0]  fifo_count;

  always #5 clk = ~clk;

  instr_issue_seq #(
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_valid   (wr_valid),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .run        (run),
    .cpu_in     (cpu_in),
    .cpu_load   (cpu_load),
    .cpu_s      (cpu_s),
    .cpu_w      (cpu_w),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .issued_cnt (issued_cnt),
    .fifo_count (fifo_count)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] alu(
    input logic [1:0] op,
    input logic [15:0] a,
    input logic [15:0] b
  );
    case (op)
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return a & b;
      default: return a ^ b;
    endcase
  endfunction

  // Simple CPU: Wait (w=1) -> Decode (w=1) -> Execute (w=0).
  // Unknown opcodes hang in Decode.
  typedef enum logic [1:0] {C_WAIT, C_DEC, C_EXE} cst_e;
  cst_e        cst = C_WAIT;
  logic [15:0] ir = '0;
  int          exe_left = 0;
  logic [15:0] creg [4];
  logic [15:0] rref [4];

  initial begin
    for (int i = 0; i < 4; i++) begin
      creg[i] = '0;
      rref[i] = '0;
    end
  end

  assign cpu_w = (cst != C_EXE);

  always @(posedge clk) begin
    if (reset) begin
      cst      <= C_WAIT;
      exe_left <= 0;
    end else begin
      if (cpu_load) ir <= cpu_in;
      case (cst)
        C_WAIT: if (cpu_s) cst <= C_DEC;
        C_DEC: begin
          if (ir[15:13] == OPC_MOV || ir[15:13] == OPC_ALU) begin
            cst      <= C_EXE;
            exe_left <= int'($urandom_range(1, 3));
          end
        end
        C_EXE: begin
          if (exe_left > 1) begin
            exe_left <= exe_left - 1;
          end else begin
            cst <= C_WAIT;
            if (ir[15:13] == OPC_MOV)
              creg[ir[9:8]] <= {8'h00, ir[7:0]};
            else
              creg[ir[9:8]] <= alu(ir[12:11],
                                   creg[ir[7:6]],
                                   creg[ir[5:4]]);
          end
        end
        default: cst <= C_WAIT;
      endcase
    end
  end

  // Reference: instructions leave in push order; architectural
  // effect of each is applied when it is handed to the CPU.
  logic [15:0] q [$];
  int          n_load = 0;
  int          n_done = 0;
  logic        prev_load = 1'b0;

  task automatic ref_exec(input logic [15:0] i);
    if (i[15:13] == OPC_MOV)
      rref[i[9:8]] = 16'(i[7:0]);
    else if (i[15:13] == OPC_ALU)
      rref[i[9:8]] = alu(i[12:11], rref[i[7:6]], rref[i[5:4]]);
  endtask

  always @(negedge clk) begin
    #4;
    if (reset) begin
      q.delete();
      prev_load = 1'b0;
    end else begin
      chk("fifo_count", int'(fifo_count), q.size());
      chk("wr_ready", int'(wr_ready), int'(q.size() < DEPTH));
      chk("s_after_load", int'(cpu_s), int'(prev_load));
      if (cpu_load) begin
        n_load++;
        chk("load_while_w0", int'(cpu_w), 1);
        chk("load_in_err", int'(err), 0);
        chk("load_len", int'(prev_load), 0);
        chk("load_nonempty", int'(q.size() != 0), 1);
        if (q.size() != 0) begin
          chk("cpu_in", int'(cpu_in), int'(q[0]));
          ref_exec(q.pop_front());
        end
      end
      if (done) begin
        n_done++;
        chk("done_empty", int'(fifo_count), 0);
      end
      if (wr_valid && wr_ready) q.push_back(wr_data);
      prev_load = cpu_load;
    end
  end

  task automatic do_reset();
    reset    = 1'b1;
    wr_valid = 1'b0;
    run      = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic push(input logic [15:0] d);
    logic ok;
    wr_data  = d;
    wr_valid = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (wr_ready) break;
      @(negedge clk);
    end
    ok = wr_ready;
    @(negedge clk);
    wr_valid = 1'b0;
    chk("push_accepted", int'(ok), 1);
  endtask

  task automatic drain();
    logic idle;
    idle = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (fifo_count == 0 && !busy) begin
        idle = 1'b1;
        break;
      end
    end
    chk("drain_idle", int'(idle), 1);
    @(negedge clk);
  endtask

  function automatic logic [15:0] rnd_instr();
    if ($urandom_range(0, 1) == 0)
      return mk_mov(2'($urandom), 8'($urandom));
    return mk_alu(2'($urandom), 2'($urandom),
                  2'($urandom), 2'($urandom));
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1);
  end

  initial begin
    int d0;
    int l0;
    int n;
    int acc;
    logic [15:0] x;
    logic [15:0] y;

    // 1: single MOV
    do_reset();
    chk("rst_busy", int'(busy), 0);
    chk("rst_load", int'(cpu_load), 0);
    chk("rst_s", int'(cpu_s), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_issued", int'(issued_cnt), 0);
    chk("rst_ready", int'(wr_ready), 1);
    chk("rst_fcnt", int'(fifo_count), 0);
    push(16'hD007);
    d0 = n_done;
    run = 1'b1;
    drain();
    chk("t1_issued", int'(issued_cnt), 1);
    chk("t1_done", n_done - d0, 1);
    chk("t1_r0", int'(creg[0]), 7);

    // 2: three dependent instructions
    do_reset();
    push(16'hD007);
    push(16'hD102);
    push(16'hA240);
    d0 = n_done;
    run = 1'b1;
    drain();
    chk("t2_issued", int'(issued_cnt), 3);
    chk("t2_done", n_done - d0, 1);
    chk("t2_r2", int'(creg[2]), 9);

    // 3: full FIFO, push accepted only after first pop
    do_reset();
    for (int i = 0; i < DEPTH; i++) push(rnd_instr());
    chk("t3_full_rdy0", int'(wr_ready), 0);
    chk("t3_full_cnt0", int'(fifo_count), DEPTH);
    wr_data  = rnd_instr();
    wr_valid = 1'b1;
    run      = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cpu_load) break;
    end
    chk("t3_load_seen", int'(cpu_load), 1);
    chk("t3_load_rdy", int'(wr_ready), 0);
    chk("t3_load_cnt", int'(fifo_count), DEPTH);
    @(negedge clk);
    chk("t3_pop_cnt", int'(fifo_count), DEPTH - 1);
    chk("t3_pop_rdy", int'(wr_ready), 1);
    @(negedge clk);
    chk("t3_refill", int'(fifo_count), DEPTH);
    wr_valid = 1'b0;
    drain();
    chk("t3_issued", int'(issued_cnt), DEPTH + 1);

    // 4: undecodable word hangs the CPU -> timeout
    do_reset();
    push(16'h0000);
    run = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cpu_s) break;
    end
    chk("t4_s_seen", int'(cpu_s), 1);
    n = 0;
    for (int i = 0; i < TIMEOUT * 4; i++) begin
      @(negedge clk);
      n++;
      if (err) break;
    end
    chk("t4_to_cycles", n, TIMEOUT + 1);
    chk("t4_err", int'(err), 1);
    chk("t4_busy", int'(busy), 0);
    l0 = n_load;
    push(mk_mov(2'd3, 8'h55));
    chk("t4_accept", int'(fifo_count), 1);
    repeat (20) @(negedge clk);
    chk("t4_sticky", int'(err), 1);
    chk("t4_noload", n_load - l0, 0);
    do_reset();
    chk("t4_rst_err", int'(err), 0);
    chk("t4_rst_fcnt", int'(fifo_count), 0);

    // 5: run dropped mid-instruction
    do_reset();
    x = 16'($urandom_range(1, 255));
    y = 16'($urandom_range(1, 255));
    push(mk_mov(2'd1, x[7:0]));
    push(mk_mov(2'd2, y[7:0]));
    run = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!cpu_w) break;
    end
    chk("t5_exec_seen", int'(cpu_w), 0);
    run = 1'b0;
    l0 = n_load;
    repeat (12) @(negedge clk);
    chk("t5_issued1", int'(issued_cnt), 1);
    chk("t5_fcnt", int'(fifo_count), 1);
    chk("t5_idle", int'(busy), 0);
    chk("t5_noload", n_load - l0, 0);
    run = 1'b1;
    drain();
    chk("t5_issued2", int'(issued_cnt), 2);
    chk("t5_r1", int'(creg[1]), int'(x));
    chk("t5_r2", int'(creg[2]), int'(y));

    // 6: reset during WAIT_BUSY
    do_reset();
    run = 1'b1;
    push(mk_mov(2'd0, 8'h3C));
    drain();
    run = 1'b0;
    push(16'h0000);
    push(mk_mov(2'd1, 8'hAA));
    push(mk_mov(2'd2, 8'hBB));
    run = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cpu_s) break;
    end
    chk("t6_s_seen", int'(cpu_s), 1);
    repeat (5) @(negedge clk);
    chk("t6_pre_busy", int'(busy), 1);
    chk("t6_pre_issued", int'(issued_cnt), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("t6_busy", int'(busy), 0);
    chk("t6_fcnt", int'(fifo_count), 0);
    chk("t6_load", int'(cpu_load), 0);
    chk("t6_s", int'(cpu_s), 0);
    chk("t6_done", int'(done), 0);
    chk("t6_err", int'(err), 0);
    chk("t6_issued", int'(issued_cnt), 0);
    chk("t6_ready", int'(wr_ready), 1);

    // 7: random pushes and run toggling
    do_reset();
    acc = 0;
    for (int i = 0; i < 400; i++) begin
      wr_valid = ($urandom_range(0, 2) == 0);
      wr_data  = rnd_instr();
      run      = ($urandom_range(0, 7) != 0);
      if (wr_valid && wr_ready) acc++;
      @(negedge clk);
    end
    wr_valid = 1'b0;
    run      = 1'b1;
    drain();
    chk("t7_issued", int'(issued_cnt), acc);
    for (int k = 0; k < 4; k++)
      chk($sformatf("t7_r%0d", k), int'(creg[k]), int'(rref[k]));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
